// File: rtl/ne_codeword_llr_tx.sv
// Hard-bit to channel-LLR frame transmitter feeding the NE LDPC decoder input.
// Optional error injection is enabled by defining NE_TX_ERRINJ_EN.
module ne_codeword_llr_tx #(
  parameter int             W          = 6,
  parameter logic [W-1:0]   maxVal     = 6'b011111,
  parameter int             FRAMEWORDS = 256,
  parameter int             CODELEN    = 8176,
  parameter int             WCWIDTH    = 9,
  parameter int             GAPCYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [31:0]       bits_in,
  input  logic              bits_valid,
  output logic              bits_ready,
  output logic [32*W-1:0]   code_out,
  output logic              code_valid,
  input  logic              tx_ready,
  output logic              frame_done,
  output logic              busy
`ifdef NE_TX_ERRINJ_EN
  ,
  input  logic              inj_en,
  input  logic [WCWIDTH-1:0] inj_word,
  input  logic [4:0]        inj_bit
`endif
);

  // Handshake: a beat moves on bits_in when bits_valid && bits_ready at a clk
  // edge, and on code_out when code_valid && tx_ready at a clk edge.

  localparam int GW       = (GAPCYCLES > 1) ? $clog2(GAPCYCLES) : 1;
  localparam int GAP_LAST = (GAPCYCLES > 0) ? GAPCYCLES - 1 : 0;
  localparam logic [W-1:0] NEG_MAX = ~maxVal + 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FLUSH = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [WCWIDTH-1:0]  wc, wc_next;
  logic [GW-1:0]       gap_cnt, gap_next;
  logic [32*W-1:0]     code_next;
  logic [32*W-1:0]     mapped;
  logic                valid_next;
  logic                done_next;
  logic                xfer;
  logic                accept;

  function automatic logic is_pad(input logic [WCWIDTH-1:0] word, input int idx);
    return (32 * int'(word) + idx) >= CODELEN;
  endfunction

`ifdef NE_TX_ERRINJ_EN
  logic                inj_en_q;
  logic [WCWIDTH-1:0]  inj_word_q;
  logic [4:0]          inj_bit_q;

  // Injection target is captured once per frame so mid-frame changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inj_en_q   <= 1'b0;
      inj_word_q <= '0;
      inj_bit_q  <= '0;
    end else if (state == IDLE && frame_start) begin
      inj_en_q   <= inj_en;
      inj_word_q <= inj_word;
      inj_bit_q  <= inj_bit;
    end
  end
`endif

  assign bits_ready = (state == SEND) && (!code_valid || tx_ready);
  assign xfer       = bits_valid && bits_ready;
  assign accept     = code_valid && tx_ready;
  assign busy       = (state != IDLE);

  // Padding positions always carry a confident zero, whatever the input bit.
  always_comb begin
    mapped = '0;
    for (int i = 0; i < 32; i++) begin
      if (is_pad(wc, i) || !bits_in[i]) begin
        mapped[W*i +: W] = maxVal;
      end else begin
        mapped[W*i +: W] = NEG_MAX;
      end
`ifdef NE_TX_ERRINJ_EN
      if (inj_en_q && (wc == inj_word_q) && (inj_bit_q == 5'(i)) && !is_pad(wc, i)) begin
        mapped[W*i +: W] = ~mapped[W*i +: W] + 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_next = state;
    wc_next    = wc;
    gap_next   = gap_cnt;
    code_next  = code_out;
    valid_next = code_valid;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_next = SEND;
          wc_next    = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          code_next  = mapped;
          valid_next = 1'b1;
          wc_next    = wc + 1'b1;
          if (wc == WCWIDTH'(FRAMEWORDS - 1)) begin
            state_next = FLUSH;
          end
        end else if (accept) begin
          valid_next = 1'b0;
        end
      end
      FLUSH: begin
        if (accept) begin
          valid_next = 1'b0;
          done_next  = 1'b1;
          gap_next   = '0;
          state_next = (GAPCYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        valid_next = 1'b0;
        if (gap_cnt == GW'(GAP_LAST)) begin
          state_next = IDLE;
        end else begin
          gap_next = gap_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      wc         <= '0;
      gap_cnt    <= '0;
      code_out   <= '0;
      code_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      wc         <= wc_next;
      gap_cnt    <= gap_next;
      code_out   <= code_next;
      code_valid <= valid_next;
      frame_done <= done_next;
    end
  end

endmodule

// File: tb/tb_ne_codeword_llr_tx.sv
// Directed bench for ne_codeword_llr_tx with an expected-beat queue scoreboard.
module tb_ne_codeword_llr_tx;
  localparam int W  = 6;
  localparam int NW = 256;
  localparam int DW = 32 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_start = 1'b0;
  logic [31:0]   bits_in = '0;
  logic          bits_valid = 1'b0;
  logic          bits_ready;
  logic [DW-1:0] code_out;
  logic          code_valid;
  logic          tx_ready = 1'b1;
  logic          frame_done;
  logic          busy;
`ifdef NE_TX_ERRINJ_EN
  logic          inj_en = 1'b0;
  logic [8:0]    inj_word = '0;
  logic [4:0]    inj_bit = '0;
`endif

  ne_codeword_llr_tx dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .bits_in     (bits_in),
    .bits_valid  (bits_valid),
    .bits_ready  (bits_ready),
    .code_out    (code_out),
    .code_valid  (code_valid),
    .tx_ready    (tx_ready),
    .frame_done  (frame_done),
    .busy        (busy)
`ifdef NE_TX_ERRINJ_EN
    ,
    .inj_en      (inj_en),
    .inj_word    (inj_word),
    .inj_bit     (inj_bit)
`endif
  );

  always #5 clk = ~clk;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];
  int            done_cnt = 0;
  int            beats_acc = 0;
  int            cv_cycles = 0;
  bit            m_inj = 1'b0;
  int            m_inj_w = 0;
  int            m_inj_b = 0;
  bit            pat [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_beat(input logic [31:0] b, input int widx);
    logic [DW-1:0] r;
    logic [5:0]    f;
    int            g;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      g = 32 * widx + i;
      if (g >= 8176 || b[i] == 1'b0) f = 6'b011111;
      else f = 6'b100001;
      if (m_inj && widx == m_inj_w && i == m_inj_b && g < 8176)
        f = (f == 6'b011111) ? 6'b100001 : 6'b011111;
      r[6*i +: 6] = f;
    end
    return r;
  endfunction

  function automatic logic [31:0] gen(input int mode, input int word);
    if (mode == 0) return 32'h0;
    if (mode == 1) return (word == 0 || word == NW - 1) ? 32'hFFFFFFFF : 32'h0;
    return $urandom();
  endfunction

  // Output side: pop on every accepted beat, hold checks while stalled.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_code = '0;
  logic [DW-1:0] mon_exp;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (code_valid) cv_cycles++;
    if (prev_stall) begin
      check("stall_hold_data", code_out, prev_code);
      check("stall_hold_valid", code_valid, 1);
    end
    if (code_valid && !tx_ready) check("stall_no_ready", bits_ready, 0);
    if (code_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL pop_underflow observed=%0h expected=empty-queue-pop", code_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat", code_out, mon_exp);
        beats_acc++;
      end
    end
    prev_stall = code_valid && !tx_ready && rst;
    prev_code  = code_out;
  end

  task automatic run_frame(input int mode, input bit stall, input bit fs_send,
                           input bit fs_gap, input int abort_at);
    int          word = 0;
    int          cyc = 0;
    bit          first_seen = 1'b0;
    logic [31:0] d;
    done_cnt  = 0;
    beats_acc = 0;
    cv_cycles = 0;
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    while (word < NW && cyc < 4000) begin
      tx_ready    = stall ? pat[cyc % 4] : 1'b1;
      d           = gen(mode, word);
      bits_valid  = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      bits_in     = bits_valid ? d : $urandom();
      frame_start = fs_send && (cyc == 50);
      @(negedge clk);
      if (mode == 0 && !stall) check(first_seen ? "valid_run" : "valid_pre", code_valid, first_seen);
      if (bits_valid && bits_ready) begin
        exp_q.push_back(exp_beat(d, word));
        first_seen = 1'b1;
        word++;
      end
      if (abort_at >= 0 && word == abort_at) break;
      @(posedge clk); #1;
      cyc++;
    end
    frame_start = 1'b0;
    if (abort_at >= 0) return;
    check("words_sent", word, NW);
    bits_valid = 1'b0;
    cyc = 0;
    while (cyc < 50) begin
      @(posedge clk); #1;
      tx_ready = stall ? pat[cyc % 4] : 1'b1;
      @(negedge clk);
      if (frame_done) break;
      cyc++;
    end
    check("done_seen", frame_done, 1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      tx_ready    = 1'b1;
      frame_start = fs_gap && (k == 1);
      @(negedge clk);
      if (k == 3) check("busy_gap", busy, 1);
      if (k == 4) check("busy_idle", busy, 0);
    end
    frame_start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_stays_idle", busy, 0);
    check("done_once", done_cnt, 1);
    check("beat_count", beats_acc, NW);
    check("queue_empty", exp_q.size(), 0);
    if (!stall && mode != 2) check("valid_cycles", cv_cycles, NW);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_code_out", code_out, 0);
    check("rst_code_valid", code_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_bits_ready", bits_ready, 0);
    rst = 1'b1;

    run_frame(0, 1'b0, 1'b0, 1'b0, -1);
    run_frame(1, 1'b0, 1'b0, 1'b0, -1);
    run_frame(2, 1'b1, 1'b0, 1'b0, -1);

    run_frame(0, 1'b0, 1'b0, 1'b0, 100);
    @(posedge clk); #1;
    rst        = 1'b0;
    bits_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_code_valid", code_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_bits_ready", bits_ready, 0);
    rst = 1'b1;
    exp_q.delete();
    repeat (5) begin
      @(posedge clk); #1;
      check("abort_quiet_valid", code_valid, 0);
    end
    check("abort_no_done", done_cnt, 0);
    run_frame(0, 1'b0, 1'b0, 1'b0, -1);

    run_frame(0, 1'b0, 1'b1, 1'b1, -1);
    run_frame(2, 1'b0, 1'b1, 1'b1, -1);

`ifdef NE_TX_ERRINJ_EN
    inj_en = 1'b1; inj_word = 9'd3; inj_bit = 5'd7;
    m_inj = 1'b1; m_inj_w = 3; m_inj_b = 7;
    run_frame(0, 1'b0, 1'b0, 1'b0, -1);
    inj_word = 9'd255; inj_bit = 5'd20;
    m_inj_w = 255; m_inj_b = 20;
    run_frame(0, 1'b0, 1'b0, 1'b0, -1);
    inj_en = 1'b0;
    m_inj  = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
